flags_branch_unit: RTL and testbench
====================================

# flags_branch_unit

Architectural flag register and branch-resolution unit sitting downstream of the ALU result/flags output. Captures the 5-bit ALU flag vector on each executed ALU instruction, evaluates conditional branches against the held compare flags with same-cycle bypass, and turns overflow / divide-by-zero events into sticky exception requests delivered to the control unit over a 4-phase req/ack handshake.

## Interface
- DATA_WIDTH, 16, width of branch target and resolved PC
- CNT_WIDTH, 8, width of the saturating exception counter
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flags_we  in  1  ALU instruction executed this cycle; capture rflags_in
- flags_cmp  in  1  qualifies flags_we: instruction was CMP (updates compare bits)
- rflags_in  in  5  ALU flags: [4] overflow, [3] greater, [2] equal, [1] less, [0] div-by-zero
- br_valid  in  1  branch instruction present this cycle
- br_cond  in  3  condition code (see Operation)
- br_target  in  DATA_WIDTH  branch destination
- pc_next  in  DATA_WIDTH  fall-through PC
- br_done  out  1  one-cycle pulse: branch resolved
- br_taken  out  1  resolution result, valid with br_done
- br_pc  out  DATA_WIDTH  br_target if taken else pc_next, valid with br_done
- flags_q  out  5  architectural flag register
- exc_req  out  1  exception request to control unit
- exc_code  out  2  [0] overflow, [1] div-by-zero; stable while exc_req high
- exc_ack  in  1  control unit acknowledge
- stall  out  1  high while exception FSM not IDLE
- exc_cnt  out  CNT_WIDTH  exceptions acknowledged since reset, saturating

## Operation
- Flag capture on flags_we: flags_q[4] and flags_q[0] always loaded from rflags_in; flags_q[3:1] loaded only when flags_cmp=1, else held. flags_cmp without flags_we ignored.
- Sticky pend bits ovf_pend / dz_pend set on flags_we with rflags_in[4] / rflags_in[0].
- Conditions: 000 always, 001 EQ (f[2]), 010 NE (!f[2]), 011 GT (f[3]), 100 LT (f[1]), 101 GE (f[3]|f[2]), 110 LE (f[1]|f[2]), 111 OV (f[4]).
- Bypass: f = flags_q, except when flags_we same cycle: f[4] = rflags_in[4]; and if also flags_cmp, f[3:1] = rflags_in[3:1].
- Exception FSM:
  - IDLE: if ovf_pend|dz_pend -> REQ; latch exc_code = {dz_pend, ovf_pend}.
  - REQ: exc_req=1, exc_code frozen; on exc_ack=1 -> CLR; clear pend bits present in exc_code; exc_cnt += 1 (saturate at all-ones).
  - CLR: exc_req=0; stay while exc_ack=1; -> IDLE when exc_ack=0.
- Set wins: a pend bit set by flags_we in the same cycle it is cleared stays set and raises a new request after returning to IDLE.
- exc_ack in IDLE ignored.

## Timing
- Reset: flags_q=0, br_done=0, br_taken=0, br_pc=0, exc_req=0, exc_code=0, stall=0, exc_cnt=0, pend bits 0, FSM IDLE. Reset mid-handshake aborts to IDLE, pending exceptions discarded.
- Branch latency 1: br_valid at edge N -> br_done/br_taken/br_pc registered at edge N+1. Back-to-back branches resolve every cycle.
- Flag capture latency 1: flags_q reflects rflags_in after the flags_we edge.
- Exception: flags_we with overflow at edge N -> pend at N+1 -> exc_req/stall high at N+2. exc_req falls the cycle after ack is sampled; next request no earlier than one cycle after ack seen low.
- stall registered, equals (state != IDLE).

## Test plan
- Reset: rst_n low mid-REQ -> all outputs 0 immediately, FSM IDLE, no further exc_req after release.
- CMP 5 vs 3 (rflags_in=5'b01000, flags_cmp=1), then br_cond=011, target 0x0040, pc_next 0x0011 -> br_taken=1, br_pc=0x0040 one cycle later.
- Same-cycle bypass: flags_cmp with 5'b00100 and br_cond=001 same cycle, flags_q previously 5'b01000 -> br_taken=1; non-CMP ADD between CMP and branch leaves f[3:1] intact.
- Overflow ADD (5'b10000) -> exc_req high 2 cycles later, exc_code=01; ack held 3 cycles -> exc_req low, stall low after ack drops, exc_cnt=1.
- DIV by zero arriving in ack cycle of pending overflow -> first code 01 cleared, second request code 10 issued after CLR->IDLE.
- 256 acknowledged exceptions with CNT_WIDTH=8 -> exc_cnt saturates at 255.

Source files
------------

// File: rtl/flags_branch_unit_if.sv
// rtl/flags_branch_unit_if.sv - bundled flag, branch and exception signals of flags_branch_unit
// Purpose: groups every non-clock/reset signal of flags_branch_unit.
// Ports (master = pipeline/control side, slave = flags_branch_unit):
//   flags_we, flags_cmp, rflags_in[4:0]       ALU flag capture
//   br_valid, br_cond[2:0], br_target, pc_next branch request
//   br_done, br_taken, br_pc                   branch resolution
//   flags_q[4:0]                               architectural flags
//   exc_req, exc_code[1:0], exc_ack, stall     exception handshake
//   exc_cnt                                    acknowledged exception count
interface flags_branch_unit_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
);
  logic                  flags_we;
  logic                  flags_cmp;
  logic [4:0]            rflags_in;
  logic                  br_valid;
  logic [2:0]            br_cond;
  logic [DATA_WIDTH-1:0] br_target;
  logic [DATA_WIDTH-1:0] pc_next;
  logic                  br_done;
  logic                  br_taken;
  logic [DATA_WIDTH-1:0] br_pc;
  logic [4:0]            flags_q;
  logic                  exc_req;
  logic [1:0]            exc_code;
  logic                  exc_ack;
  logic                  stall;
  logic [CNT_WIDTH-1:0]  exc_cnt;

  modport master (
    output flags_we, flags_cmp, rflags_in, br_valid, br_cond, br_target, pc_next, exc_ack,
    input  br_done, br_taken, br_pc, flags_q, exc_req, exc_code, stall, exc_cnt
  );

  modport slave (
    input  flags_we, flags_cmp, rflags_in, br_valid, br_cond, br_target, pc_next, exc_ack,
    output br_done, br_taken, br_pc, flags_q, exc_req, exc_code, stall, exc_cnt
  );
endinterface

// File: rtl/flags_branch_unit.sv
// rtl/flags_branch_unit.sv - architectural flag register, branch resolution and exception requester
// Purpose: captures ALU flags, resolves conditional branches against the held compare
//   flags (with same-cycle bypass), and raises sticky overflow / divide-by-zero
//   exceptions to the control unit over a 4-phase req/ack handshake.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    flags_branch_unit_if.slave (see interface file for the signal list)
module flags_branch_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input logic                clk,
  input logic                rst_n,
  flags_branch_unit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_CLR  = 2'd2
  } state_e;

  state_e                state_q;
  logic [4:0]            flag_reg_q, flag_reg_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic                  dz_pend_q, dz_pend_d;
  logic                  exc_req_q;
  logic                  stall_q;
  logic [1:0]            exc_code_q;
  logic [CNT_WIDTH-1:0]  exc_cnt_q;
  logic                  br_done_q;
  logic                  br_taken_q;
  logic [DATA_WIDTH-1:0] br_pc_q;

  logic [4:1]            eff_flags;
  logic                  cond_true;
  logic                  ack_in_req;

  assign ack_in_req = (state_q == S_REQ) && bus.exc_ack;

  // Next flag register value, branch-visible flags and sticky pend bits.
  // The branch sees this cycle's ALU flags when they are being written, so a
  // CMP followed immediately by a branch in the same cycle resolves correctly.
  always_comb begin
    flag_reg_d = flag_reg_q;
    eff_flags  = flag_reg_q[4:1];
    if (bus.flags_we) begin
      flag_reg_d[4] = bus.rflags_in[4];
      flag_reg_d[0] = bus.rflags_in[0];
      eff_flags[4]  = bus.rflags_in[4];
      if (bus.flags_cmp) begin
        flag_reg_d[3:1] = bus.rflags_in[3:1];
        eff_flags[3:1]  = bus.rflags_in[3:1];
      end
    end
    // A new event in the acknowledge cycle wins over the clear.
    ovf_pend_d = (ovf_pend_q && !(ack_in_req && exc_code_q[0])) ||
                 (bus.flags_we && bus.rflags_in[4]);
    dz_pend_d  = (dz_pend_q && !(ack_in_req && exc_code_q[1])) ||
                 (bus.flags_we && bus.rflags_in[0]);
  end

  always_comb begin
    cond_true = 1'b0;
    case (bus.br_cond)
      3'b000:  cond_true = 1'b1;
      3'b001:  cond_true = eff_flags[2];
      3'b010:  cond_true = !eff_flags[2];
      3'b011:  cond_true = eff_flags[3];
      3'b100:  cond_true = eff_flags[1];
      3'b101:  cond_true = eff_flags[3] | eff_flags[2];
      3'b110:  cond_true = eff_flags[1] | eff_flags[2];
      3'b111:  cond_true = eff_flags[4];
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_reg_q <= '0;
      ovf_pend_q <= 1'b0;
      dz_pend_q  <= 1'b0;
    end else begin
      flag_reg_q <= flag_reg_d;
      ovf_pend_q <= ovf_pend_d;
      dz_pend_q  <= dz_pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_done_q  <= 1'b0;
      br_taken_q <= 1'b0;
      br_pc_q    <= '0;
    end else begin
      br_done_q  <= bus.br_valid;
      br_taken_q <= bus.br_valid && cond_true;
      if (bus.br_valid) begin
        br_pc_q <= cond_true ? bus.br_target : bus.pc_next;
      end
    end
  end

  // Exception handshake FSM. exc_code is latched on entry to REQ and only
  // changes on the next entry, so it is stable for the whole request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      exc_req_q  <= 1'b0;
      stall_q    <= 1'b0;
      exc_code_q <= '0;
      exc_cnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ovf_pend_q || dz_pend_q) begin
            state_q    <= S_REQ;
            exc_req_q  <= 1'b1;
            stall_q    <= 1'b1;
            exc_code_q <= {dz_pend_q, ovf_pend_q};
          end
        end
        S_REQ: begin
          if (bus.exc_ack) begin
            state_q   <= S_CLR;
            exc_req_q <= 1'b0;
            if (exc_cnt_q != {CNT_WIDTH{1'b1}}) begin
              exc_cnt_q <= exc_cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        S_CLR: begin
          if (!bus.exc_ack) begin
            state_q <= S_IDLE;
            stall_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          exc_req_q <= 1'b0;
          stall_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.flags_q  = flag_reg_q;
  assign bus.br_done  = br_done_q;
  assign bus.br_taken = br_taken_q;
  assign bus.br_pc    = br_pc_q;
  assign bus.exc_req  = exc_req_q;
  assign bus.exc_code = exc_code_q;
  assign bus.stall    = stall_q;
  assign bus.exc_cnt  = exc_cnt_q;

endmodule

// File: tb/tb_flags_branch_unit.sv
// tb/tb_flags_branch_unit.sv - self-checking bench for flags_branch_unit
module tb_flags_branch_unit;
  localparam int DW = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  flags_branch_unit_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();
  flags_branch_unit #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic          taken;
    logic [DW-1:0] pc;
  } br_exp_t;

  br_exp_t exp_q[$];
  int      checks = 0;
  int      errors = 0;
  int      exp_cnt = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.flags_we  = 1'b0;
    bus.flags_cmp = 1'b0;
    bus.rflags_in = 5'b0;
    bus.br_valid  = 1'b0;
    bus.br_cond   = 3'b0;
    bus.br_target = '0;
    bus.pc_next   = '0;
  endtask

  // Drives a branch for one cycle and records the expected resolution.
  task automatic drive_branch(input logic [2:0] c, input logic [DW-1:0] t,
                              input logic [DW-1:0] p, input logic exp_taken);
    br_exp_t e;
    bus.br_valid  = 1'b1;
    bus.br_cond   = c;
    bus.br_target = t;
    bus.pc_next   = p;
    e.taken = exp_taken;
    e.pc    = exp_taken ? t : p;
    exp_q.push_back(e);
  endtask

  // Scoreboard pop side: every br_done pulse is matched against the queue.
  always @(posedge clk) begin
    br_exp_t e;
    #1;
    if (rst_n === 1'b1 && bus.br_done === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL br_unexpected: br_done=1 with no branch outstanding");
      end else begin
        e = exp_q.pop_front();
        if (bus.br_taken !== e.taken || bus.br_pc !== e.pc) begin
          errors++;
          $display("FAIL br_result: taken=%b pc=%h expected taken=%b pc=%h",
                   bus.br_taken, bus.br_pc, e.taken, e.pc);
        end
      end
    end
  end

  task automatic fire_exception(input logic [4:0] fl);
    bus.flags_we  = 1'b1;
    bus.flags_cmp = 1'b0;
    bus.rflags_in = fl;
    tick;
    idle_inputs;
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 8 && bus.exc_req !== 1'b1; i++) tick;
    checks++;
    if (bus.exc_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_wait_req: exc_req=%b expected 1 within 8 cycles", name, bus.exc_req);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.exc_ack = 1'b0;
    idle_inputs;
    tick;
    tick;
    checks++;
    if ({bus.br_done, bus.br_taken, bus.exc_req, bus.stall} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: done,taken,req,stall=%b expected 0000",
               {bus.br_done, bus.br_taken, bus.exc_req, bus.stall});
    end
    checks++;
    if (bus.br_pc !== '0 || bus.flags_q !== 5'b0) begin
      errors++;
      $display("FAIL reset_data: br_pc=%h flags_q=%b expected 0", bus.br_pc, bus.flags_q);
    end
    checks++;
    if (bus.exc_code !== 2'b0 || bus.exc_cnt !== '0) begin
      errors++;
      $display("FAIL reset_exc: exc_code=%b exc_cnt=%0d expected 0", bus.exc_code, bus.exc_cnt);
    end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_cmp_branch;
    bus.flags_we  = 1'b1;
    bus.flags_cmp = 1'b1;
    bus.rflags_in = 5'b01000;
    tick;
    idle_inputs;
    checks++;
    if (bus.flags_q !== 5'b01000) begin
      errors++;
      $display("FAIL cmp_capture: flags_q=%b expected 01000", bus.flags_q);
    end
    drive_branch(3'b011, 16'h0040, 16'h0011, 1'b1);
    tick;
    idle_inputs;
    checks++;
    if (bus.br_done !== 1'b1 || bus.br_taken !== 1'b1 || bus.br_pc !== 16'h0040) begin
      errors++;
      $display("FAIL cmp_gt_branch: done=%b taken=%b pc=%h expected 1 1 0040",
               bus.br_done, bus.br_taken, bus.br_pc);
    end
    tick;
    checks++;
    if (bus.br_done !== 1'b0) begin
      errors++;
      $display("FAIL br_done_pulse: br_done=%b expected 0", bus.br_done);
    end
  endtask

  // Flags held at 01000 (greater): every condition code on consecutive cycles.
  task automatic test_back_to_back;
    logic [7:0] taken_tbl;
    taken_tbl = 8'b0010_1101;
    for (int i = 0; i < 8; i++) begin
      drive_branch(3'(i), 16'h1000 + 16'(i), 16'h2000 + 16'(i), taken_tbl[i]);
      tick;
      if (i > 0) begin
        checks++;
        if (bus.br_done !== 1'b1) begin
          errors++;
          $display("FAIL b2b_done_%0d: br_done=%b expected 1", i, bus.br_done);
        end
      end
    end
    idle_inputs;
    tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_drain: %0d branches unresolved, expected 0", exp_q.size());
    end
  endtask

  task automatic test_bypass;
    // CMP writing "equal" with an EQ branch in the same cycle.
    bus.flags_we  = 1'b1;
    bus.flags_cmp = 1'b1;
    bus.rflags_in = 5'b00100;
    drive_branch(3'b001, 16'h0100, 16'h0101, 1'b1);
    tick;
    idle_inputs;
    checks++;
    if (bus.flags_q !== 5'b00100) begin
      errors++;
      $display("FAIL bypass_capture: flags_q=%b expected 00100", bus.flags_q);
    end
    // CMP greater, then a non-CMP ADD must not disturb the compare bits.
    bus.flags_we  = 1'b1;
    bus.flags_cmp = 1'b1;
    bus.rflags_in = 5'b01000;
    tick;
    bus.flags_cmp = 1'b0;
    bus.rflags_in = 5'b00100;
    tick;
    idle_inputs;
    checks++;
    if (bus.flags_q !== 5'b01000) begin
      errors++;
      $display("FAIL add_keeps_cmp: flags_q=%b expected 01000", bus.flags_q);
    end
    drive_branch(3'b011, 16'h0200, 16'h0201, 1'b1);
    tick;
    drive_branch(3'b001, 16'h0300, 16'h0301, 1'b0);
    tick;
    // Non-CMP ADD in the branch cycle: compare bits come from flags_q.
    bus.flags_we  = 1'b1;
    bus.rflags_in = 5'b00010;
    drive_branch(3'b100, 16'h0400, 16'h0401, 1'b0);
    tick;
    idle_inputs;
    // flags_cmp without flags_we is ignored.
    bus.flags_cmp = 1'b1;
    bus.rflags_in = 5'b00010;
    drive_branch(3'b100, 16'h0500, 16'h0501, 1'b0);
    tick;
    idle_inputs;
    checks++;
    if (bus.flags_q !== 5'b01000) begin
      errors++;
      $display("FAIL cmp_without_we: flags_q=%b expected 01000", bus.flags_q);
    end
    tick;
  endtask

  task automatic test_overflow;
    fire_exception(5'b10000);
    checks++;
    if (bus.exc_req !== 1'b0) begin
      errors++;
      $display("FAIL ovf_early: exc_req=%b expected 0 one cycle after ADD", bus.exc_req);
    end
    tick;
    checks++;
    if (bus.exc_req !== 1'b1 || bus.stall !== 1'b1 || bus.exc_code !== 2'b01) begin
      errors++;
      $display("FAIL ovf_req: req=%b stall=%b code=%b expected 1 1 01",
               bus.exc_req, bus.stall, bus.exc_code);
    end
    tick;
    checks++;
    if (bus.exc_req !== 1'b1 || bus.exc_code !== 2'b01) begin
      errors++;
      $display("FAIL ovf_hold: req=%b code=%b expected 1 01", bus.exc_req, bus.exc_code);
    end
    bus.exc_ack = 1'b1;
    tick;
    exp_cnt++;
    checks++;
    if (bus.exc_req !== 1'b0 || bus.stall !== 1'b1 || bus.exc_cnt !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL ovf_ack: req=%b stall=%b cnt=%0d expected 0 1 %0d",
               bus.exc_req, bus.stall, bus.exc_cnt, exp_cnt);
    end
    tick;
    tick;
    checks++;
    if (bus.stall !== 1'b1 || bus.exc_req !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clr_hold: stall=%b req=%b expected 1 0", bus.stall, bus.exc_req);
    end
    bus.exc_ack = 1'b0;
    tick;
    checks++;
    if (bus.stall !== 1'b0 || bus.exc_req !== 1'b0) begin
      errors++;
      $display("FAIL ovf_release: stall=%b req=%b expected 0 0", bus.stall, bus.exc_req);
    end
    tick;
    checks++;
    if (bus.exc_req !== 1'b0) begin
      errors++;
      $display("FAIL ovf_no_repeat: exc_req=%b expected 0", bus.exc_req);
    end
  endtask

  task automatic test_dz_in_ack;
    fire_exception(5'b10000);
    wait_req("dz");
    checks++;
    if (bus.exc_code !== 2'b01) begin
      errors++;
      $display("FAIL dz_first_code: exc_code=%b expected 01", bus.exc_code);
    end
    bus.exc_ack   = 1'b1;
    bus.flags_we  = 1'b1;
    bus.rflags_in = 5'b00001;
    tick;
    idle_inputs;
    exp_cnt++;
    checks++;
    if (bus.exc_req !== 1'b0) begin
      errors++;
      $display("FAIL dz_ack_drop: exc_req=%b expected 0", bus.exc_req);
    end
    tick;
    bus.exc_ack = 1'b0;
    tick;
    checks++;
    if (bus.stall !== 1'b0 || bus.exc_req !== 1'b0) begin
      errors++;
      $display("FAIL dz_idle_gap: stall=%b req=%b expected 0 0", bus.stall, bus.exc_req);
    end
    tick;
    checks++;
    if (bus.exc_req !== 1'b1 || bus.exc_code !== 2'b10) begin
      errors++;
      $display("FAIL dz_second_req: req=%b code=%b expected 1 10", bus.exc_req, bus.exc_code);
    end
    bus.exc_ack = 1'b1;
    tick;
    exp_cnt++;
    bus.exc_ack = 1'b0;
    tick;
    checks++;
    if (bus.exc_cnt !== CW'(exp_cnt) || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL dz_count: cnt=%0d stall=%b expected %0d 0", bus.exc_cnt, bus.stall, exp_cnt);
    end
  endtask

  task automatic test_ack_idle;
    bus.exc_ack = 1'b1;
    tick;
    tick;
    tick;
    checks++;
    if (bus.stall !== 1'b0 || bus.exc_req !== 1'b0 || bus.exc_cnt !== CW'(exp_cnt)) begin
      errors++;
      $display("FAIL ack_in_idle: stall=%b req=%b cnt=%0d expected 0 0 %0d",
               bus.stall, bus.exc_req, bus.exc_cnt, exp_cnt);
    end
    bus.exc_ack = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid_req;
    logic seen_req;
    fire_exception(5'b10000);
    wait_req("rst");
    fire_exception(5'b00001);
    #2;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks++;
    if ({bus.exc_req, bus.stall, bus.exc_code} !== 4'b0 || bus.exc_cnt !== '0 ||
        bus.flags_q !== 5'b0) begin
      errors++;
      $display("FAIL reset_async: req=%b stall=%b code=%b cnt=%0d flags=%b expected all 0",
               bus.exc_req, bus.stall, bus.exc_code, bus.exc_cnt, bus.flags_q);
    end
    tick;
    tick;
    rst_n = 1'b1;
    seen_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (bus.exc_req === 1'b1 || bus.stall === 1'b1) seen_req = 1'b1;
    end
    checks++;
    if (seen_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: request seen after reset release, expected none");
    end
  endtask

  task automatic test_saturation;
    for (int n = 1; n <= 256; n++) begin
      fire_exception(5'b10000);
      wait_req("sat");
      bus.exc_ack = 1'b1;
      tick;
      bus.exc_ack = 1'b0;
      tick;
      if (exp_cnt < 255) exp_cnt++;
      checks++;
      if (bus.exc_cnt !== CW'(exp_cnt)) begin
        errors++;
        $display("FAIL sat_count_%0d: exc_cnt=%0d expected %0d", n, bus.exc_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_cmp_branch;
    test_back_to_back;
    test_bypass;
    test_overflow;
    test_dz_in_ack;
    test_ack_idle;
    test_reset_mid_req;
    test_saturation;
    tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d branches unresolved, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
